// File: rtl/tdm_frame_controller.sv
// TDM receive sequencer: frame sync generation, per-frame channel snapshot,
// and streaming of the enabled channels over a valid/ready interface.
module tdm_frame_controller #(
    parameter int NUM_CH     = 5,
    parameter int WORD_W     = 32,
    parameter int FRAME_BITS = 160,
    parameter int CNT_W      = 16
) (
    input  logic                     tdm_clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic                     tdm_sync,
    input  logic                     word_ready,
    input  logic [NUM_CH*WORD_W-1:0] ch_bus,
    output logic [WORD_W-1:0]        out_data,
    output logic [2:0]               out_chan,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [CNT_W-1:0]         frame_count
);
    localparam int BC_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state_q, state_d;
    logic [BC_W-1:0]            bit_cnt_q;
    logic                       sync_q;
    logic [NUM_CH*WORD_W-1:0]   snap_q, snap_d;
    logic [NUM_CH-1:0]          mask_q, mask_d;
    logic [2:0]                 idx_q, idx_d;
    logic                       valid_q, valid_d;
    logic [WORD_W-1:0]          data_q, data_d;
    logic [2:0]                 chan_q, chan_d;
    logic                       last_q, last_d;
    logic                       ovf_q, ovf_d;
    logic [CNT_W-1:0]           fcnt_q;

    // Lowest set bit of m at or above position start (0 if none).
    function automatic logic [2:0] first_from(input logic [NUM_CH-1:0] m, input logic [3:0] start);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (i >= int'(start) && m[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic any_above(input logic [NUM_CH-1:0] m, input logic [2:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (i > int'(idx) && m[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] word_sel(input logic [NUM_CH*WORD_W-1:0] bus, input logic [2:0] idx);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (3'(i) == idx) r = bus[i*WORD_W +: WORD_W];
        return r;
    endfunction

    always_ff @(posedge tdm_clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            sync_q    <= 1'b0;
        end else if (!enable) begin
            bit_cnt_q <= '0;
            sync_q    <= 1'b0;
        end else begin
            sync_q    <= (bit_cnt_q == '0);
            bit_cnt_q <= (bit_cnt_q == BC_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    logic       hs, last_hs, load;
    logic [2:0] nidx;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        nidx    = first_from(mask_q, {1'b0, idx_q} + 4'd1);
        hs      = valid_q && out_ready;
        last_hs = hs && last_q;

        if (clear_overflow) ovf_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (word_ready && ch_mask != '0) load = 1'b1;
            end
            SEND: begin
                // A frame arriving before the final beat is accepted is dropped.
                if (word_ready && !last_hs) ovf_d = 1'b1;
                if (last_hs && word_ready && ch_mask != '0) begin
                    load = 1'b1;
                end else if (last_hs) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (hs) begin
                    idx_d  = nidx;
                    data_d = word_sel(snap_q, nidx);
                    chan_d = nidx;
                    last_d = !any_above(mask_q, nidx);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            snap_d  = ch_bus;
            mask_d  = ch_mask;
            idx_d   = first_from(ch_mask, 4'd0);
            state_d = SEND;
            valid_d = 1'b1;
            data_d  = word_sel(ch_bus, idx_d);
            chan_d  = idx_d;
            last_d  = !any_above(ch_mask, idx_d);
        end
    end

    always_ff @(posedge tdm_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            if (word_ready) fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign tdm_sync    = sync_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_chan    = chan_q;
    assign out_last    = last_q;
    assign overflow    = ovf_q;
    assign frame_count = fcnt_q;

endmodule

// File: doc/tdm_frame_controller.md
Name: tdm_frame_controller

Overview:
- Sequences the TDM receive path.
- Generates the frame sync pulse for tdm_deserializer on the shared TDM bit clock.
- On each word_ready, snapshots the deserializer's parallel channel words and streams the enabled channels, one per handshake, to a downstream valid/ready consumer.
- Detects and flags frames that arrive before the previous frame has drained.

Parameters:
- NUM_CH, 5, number of TDM channels (≤8).
- WORD_W, 32, bits per channel word.
- FRAME_BITS, 160, tdm_clk cycles per frame (NUM_CH*WORD_W).
- CNT_W, 16, frame counter width.

Ports:
- tdm_clk  in  1  TDM bit clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  runs the sync generator.
- ch_mask  in  NUM_CH  channel enable mask; sampled when word_ready is accepted.
- tdm_sync  out  1  frame sync to the deserializer.
- word_ready  in  1  one-cycle pulse from the deserializer: frame words valid.
- ch_bus  in  NUM_CH*WORD_W  channel n at bits [n*WORD_W +: WORD_W].
- out_data  out  WORD_W  streamed channel word.
- out_chan  out  3  channel index of out_data.
- out_last  out  1  marks the last enabled channel of the frame.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- overflow  out  1  sticky frame-dropped flag.
- clear_overflow  in  1  clears overflow.
- frame_count  out  CNT_W  count of word_ready pulses received; wraps.

Behaviour:
- Reset (async): bit_cnt=0, tdm_sync=0, out_valid=0, out_data=0, out_chan=0, out_last=0, overflow=0, frame_count=0, FSM=IDLE, snapshot=0. Reset mid-stream drops the word in flight without a handshake.
- Sync generator:
  - enable=0: bit_cnt held at 0, tdm_sync=0.
  - enable=1: tdm_sync is registered and asserts for exactly one cycle in the cycle after bit_cnt==0 is observed. bit_cnt increments each cycle and wraps FRAME_BITS-1 -> 0.
  - Result: period is FRAME_BITS cycles; first pulse lands 1 cycle after enable rises.
  - Deasserting enable mid-frame returns bit_cnt to 0 on the next edge.
- frame_count: +1 on every word_ready cycle, including dropped frames; wraps at 2^CNT_W.
- FSM states are IDLE and SEND.
- IDLE:
  - word_ready with ch_mask!=0: latch ch_bus into the snapshot and ch_mask into the mask register; idx = lowest set bit of mask; go to SEND.
  - word_ready with ch_mask==0: count the frame, emit nothing, stay IDLE.
- SEND:
  - out_valid=1, out_data=snap[idx], out_chan=idx, out_last=1 iff no higher mask bit is set.
  - Outputs are registered; out_data, out_chan and out_last stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: advance idx to the next higher set mask bit (next word presented the following cycle, zero bubble). After out_last, return to IDLE with out_valid=0.
- Overflow: word_ready in SEND, other than in the final-handshake cycle, drops the new frame (snapshot untouched, current frame continues) and sets overflow.
- Simultaneous events:
  - word_ready in the same cycle as the out_last handshake: the new frame is accepted (no overflow). Snapshot reloads and the FSM stays in SEND with idx = lowest bit of the new mask. If the new ch_mask==0, go to IDLE.
  - Overflow set and clear_overflow in the same cycle: set wins.
- Throughput: per frame, popcount(ch_mask) stream beats; the first beat's out_valid asserts 1 cycle after word_ready.

Test Plan:
- Reset, enable=1 for 400 cycles -> tdm_sync pulses at cycles 1, 161, 321 after enable, each exactly 1 cycle wide; enable dropped at cycle 200 -> no pulse at 321, bit_cnt=0.
- ch_bus ch0..ch4 = 0x11111111..0x55555555, ch_mask=5'b11111, out_ready=1, word_ready pulse -> 5 consecutive beats with out_chan 0..4 and matching data; out_last only on chan 4; frame_count=1.
- ch_mask=5'b10010, out_ready toggled 1/0 each cycle -> beats chan1=0x22222222 then chan4=0x55555555 (out_last); data held stable during out_ready=0 cycles.
- out_ready=0, second word_ready 20 cycles after first -> overflow=1, frame_count=2, stream still delivers first-frame data. clear_overflow pulse -> overflow=0; clear coincident with a new drop -> overflow stays 1.
- word_ready coincident with out_last handshake -> no overflow, next beat is the new frame's lowest enabled channel on the following cycle. ch_mask=0 frame -> no beats, frame_count increments.
- Assert reset while out_valid=1 mid-frame -> all outputs zero immediately (asynchronously). Next word_ready after release streams the full new frame from the lowest enabled channel.
